// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared opcode and phase encodings for the 8-bit
//                accumulator CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int OPCODE_W = 3;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/phase_counter.sv
`default_nettype none
// ============================================================================
//  Module      : phase_counter
//  Description : Generic wrapping up-counter with a hold input and
//                asynchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Count up every cycle unless held; wraps naturally at 2**WIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (!hold) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : phase_counter
`default_nettype wire

// File: rtl/risc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : risc_sequencer
//  Description : 8-phase instruction sequencer and control decoder for the
//                accumulator CPU. Stops on HLT until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module risc_sequencer
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = cpu_pkg::OPCODE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                mem_rd,
    output logic                load_ir,
    output logic                inc_pc,
    output logic                load_pc,
    output logic                load_ac,
    output logic                mem_wr,
    output logic                halt,
    output logic [2:0]          phase
);

    logic [2:0] w_count;
    phase_t     w_phase;
    opcode_t    w_op;
    logic       w_aluop;
    logic       w_halt_now;
    logic       w_hold;
    logic       r_halted;

    assign w_phase    = phase_t'(w_count);
    assign w_op       = opcode_t'(opcode);
    assign w_aluop    = (w_op == ADD) || (w_op == AND) ||
                        (w_op == XOR) || (w_op == LDA);
    assign w_halt_now = (w_phase == OP_ADDR) && (w_op == HLT);
    // Holding on the HLT edge itself keeps the phase parked at OP_ADDR
    // on the same edge that sets the halted flag.
    assign w_hold     = r_halted || w_halt_now;

    phase_counter #(
        .WIDTH (3)
    ) u_phase_counter (
        .clk   (clk),
        .rst   (rst),
        .hold  (w_hold),
        .count (w_count)
    );

    // Sticky halted flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halted <= 1'b0;
        end else if (w_halt_now) begin
            r_halted <= 1'b1;
        end
    end

    // Control decode from phase, halted flag and opcode.
    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        inc_pc  = 1'b0;
        load_pc = 1'b0;
        load_ac = 1'b0;
        mem_wr  = 1'b0;
        halt    = 1'b0;
        if (r_halted) begin
            halt = 1'b1;
        end else begin
            case (w_phase)
                INST_ADDR: ;
                INST_FETCH: begin
                    mem_rd = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (w_op == HLT);
                end
                OP_FETCH: begin
                    mem_rd = w_aluop;
                end
                ALU_OP: begin
                    mem_rd  = w_aluop;
                    load_ac = w_aluop;
                    inc_pc  = (w_op == SKZ) && zero;
                    load_pc = (w_op == JMP);
                end
                STORE: begin
                    mem_rd  = w_aluop;
                    load_ac = w_aluop;
                    inc_pc  = (w_op == JMP);
                    load_pc = (w_op == JMP);
                    mem_wr  = (w_op == STO);
                end
                default: ;
            endcase
        end
    end

    assign phase = w_count;

endmodule : risc_sequencer
`default_nettype wire

// File: tb/tb_risc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_risc_sequencer
//  Description : Directed self-checking bench for risc_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_risc_sequencer;

    // Strobe vector order: {mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, halt}
    localparam logic [6:0] S_NONE  = 7'b0000000;
    localparam logic [6:0] S_FETCH = 7'b1000000;
    localparam logic [6:0] S_LOAD  = 7'b1100000;
    localparam logic [6:0] S_INC   = 7'b0010000;
    localparam logic [6:0] S_HALT  = 7'b0000001;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, halt;
    logic [2:0] phase;

    int n_checks;
    int n_errors;

    risc_sequencer #(
        .OPCODE_W (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .zero    (zero),
        .mem_rd  (mem_rd),
        .load_ir (load_ir),
        .inc_pc  (inc_pc),
        .load_pc (load_pc),
        .load_ac (load_ac),
        .mem_wr  (mem_wr),
        .halt    (halt),
        .phase   (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] strobes();
        return {mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, halt};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Holds reset for two clocks, checks quiet outputs, releases at a negedge.
    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_phase", {5'd0, phase}, 8'd0);
        check("rst_strobes", {1'b0, strobes()}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Runs one full instruction from INST_ADDR, checking phase and strobes
    // at each negedge against the hand-computed table exp[phase].
    task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                             input logic [7:0][6:0] exp);
        opcode = op;
        zero   = z;
        for (int p = 0; p < 8; p++) begin
            check($sformatf("%s_ph%0d_phase", tag, p), {5'd0, phase}, p[7:0]);
            check($sformatf("%s_ph%0d_strb", tag, p), {1'b0, strobes()}, {1'b0, exp[p]});
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        opcode   = 3'd2;
        zero     = 1'b0;

        do_reset();

        // ADD, zero=0
        run_instr("add", 3'd2, 1'b0, {7'b1000100, 7'b1000100, S_FETCH, S_INC,
                                      S_LOAD, S_LOAD, S_FETCH, S_NONE});
        // SKZ, zero=1: extra inc_pc in ALU_OP
        run_instr("skz1", 3'd1, 1'b1, {S_NONE, S_INC, S_NONE, S_INC,
                                       S_LOAD, S_LOAD, S_FETCH, S_NONE});
        // SKZ, zero=0: no extra inc_pc
        run_instr("skz0", 3'd1, 1'b0, {S_NONE, S_NONE, S_NONE, S_INC,
                                       S_LOAD, S_LOAD, S_FETCH, S_NONE});
        // JMP
        run_instr("jmp", 3'd7, 1'b0, {7'b0011000, 7'b0001000, S_NONE, S_INC,
                                      S_LOAD, S_LOAD, S_FETCH, S_NONE});
        // STO
        run_instr("sto", 3'd6, 1'b1, {7'b0000010, S_NONE, S_NONE, S_INC,
                                      S_LOAD, S_LOAD, S_FETCH, S_NONE});
        // LDA with zero=1 behaves as an ALU op, zero ignored
        run_instr("lda", 3'd5, 1'b1, {7'b1000100, 7'b1000100, S_FETCH, S_INC,
                                      S_LOAD, S_LOAD, S_FETCH, S_NONE});

        // HLT: phases 0-3 normal, phase 4 shows inc_pc and halt
        opcode = 3'd0;
        zero   = 1'b0;
        for (int p = 0; p < 4; p++) @(negedge clk);
        check("hlt_ph4_phase", {5'd0, phase}, 8'd4);
        check("hlt_ph4_strb", {1'b0, strobes()}, {1'b0, 7'b0010001});
        @(negedge clk);
        check("hlt_held_phase", {5'd0, phase}, 8'd4);
        check("hlt_held_strb", {1'b0, strobes()}, {1'b0, S_HALT});
        // Opcode changes must not wake a halted machine
        opcode = 3'd2;
        repeat (20) @(negedge clk);
        check("hlt_20_phase", {5'd0, phase}, 8'd4);
        check("hlt_20_strb", {1'b0, strobes()}, {1'b0, S_HALT});

        // One clock of reset restarts the sequence
        rst = 1'b0;
        #1;
        check("hlt_rst_phase", {5'd0, phase}, 8'd0);
        check("hlt_rst_strb", {1'b0, strobes()}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        run_instr("restart", 3'd2, 1'b0, {7'b1000100, 7'b1000100, S_FETCH, S_INC,
                                          S_LOAD, S_LOAD, S_FETCH, S_NONE});

        // Async reset in ALU_OP with ADD: strobes drop before the next edge
        opcode = 3'd2;
        zero   = 1'b0;
        for (int p = 0; p < 6; p++) @(negedge clk);
        check("abort_pre_phase", {5'd0, phase}, 8'd6);
        check("abort_pre_strb", {1'b0, strobes()}, {1'b0, 7'b1000100});
        #2 rst = 1'b0;
        #1;
        check("abort_now_phase", {5'd0, phase}, 8'd0);
        check("abort_now_strb", {1'b0, strobes()}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        check("abort_rel_phase", {5'd0, phase}, 8'd0);
        check("abort_rel_strb", {1'b0, strobes()}, 8'd0);
        @(negedge clk);
        check("abort_next_phase", {5'd0, phase}, 8'd1);
        check("abort_next_strb", {1'b0, strobes()}, {1'b0, S_FETCH});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_risc_sequencer
`default_nettype wire
